// File: rtl/spi_byte_sequencer.sv
// Byte-level SPI transaction sequencer: buffers TX bytes in a small FIFO and frames
// N-byte transfers with chip select lead/lag/idle timing around an SPI_Master.
module spi_byte_sequencer #(
   parameter int FIFO_DEPTH   = 8,
   parameter int CNT_W        = 8,
   parameter int CS_LEAD_CLKS = 4,
   parameter int CS_LAG_CLKS  = 4,
   parameter int CS_IDLE_CLKS = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_TX_Byte,
   input  logic             i_TX_DV,
   output logic             o_TX_Full,
   output logic             o_TX_Empty,
   input  logic             i_Start,
   input  logic [CNT_W-1:0] i_Count,
   output logic             o_Busy,
   output logic             o_Done,
   output logic [7:0]       o_RX_Byte,
   output logic             o_RX_DV,
   output logic [CNT_W-1:0] o_RX_Index,
   output logic [7:0]       o_M_TX_Byte,
   output logic             o_M_TX_DV,
   input  logic             i_M_TX_Ready,
   input  logic             i_M_RX_DV,
   input  logic [7:0]       i_M_RX_Byte,
   output logic             o_SPI_CS_n
);

   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TMR_W = 16;

   typedef enum logic [2:0] {IDLE, LEAD, LOAD, WAIT_RX, LAG, GAP} state_t;

   state_t             state, state_nxt;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        occ;
   logic               push, pop, m_dv;
   logic [TMR_W-1:0]   tmr;
   logic [CNT_W-1:0]   remaining, index;

   // A timed state is always occupied for at least one cycle, even with a zero count.
   function automatic logic tmr_done(input logic [TMR_W-1:0] t, input int n);
      return (n <= 1) || (int'(t) >= n - 1);
   endfunction

   assign o_TX_Full   = (occ == (AW+1)'(FIFO_DEPTH));
   assign o_TX_Empty  = (occ == '0);
   assign push        = i_TX_DV && !o_TX_Full;
   assign o_M_TX_DV   = m_dv;
   assign o_M_TX_Byte = m_dv ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_TX_Byte;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      m_dv      = 1'b0;
      case (state)
         IDLE:    if (i_Start && (i_Count != '0)) state_nxt = LEAD;
         LEAD:    if (tmr_done(tmr, CS_LEAD_CLKS)) state_nxt = LOAD;
         LOAD: begin
            // An empty FIFO simply stalls here with CS_n still asserted.
            if (!o_TX_Empty && i_M_TX_Ready) begin
               m_dv      = 1'b1;
               pop       = 1'b1;
               state_nxt = WAIT_RX;
            end
         end
         WAIT_RX: if (i_M_RX_DV) state_nxt = (remaining == CNT_W'(1)) ? LAG : LOAD;
         LAG:     if (tmr_done(tmr, CS_LAG_CLKS)) state_nxt = GAP;
         GAP:     if (tmr_done(tmr, CS_IDLE_CLKS)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         tmr        <= '0;
         o_SPI_CS_n <= 1'b1;
         o_Busy     <= 1'b0;
         o_Done     <= 1'b0;
         o_RX_DV    <= 1'b0;
         o_RX_Byte  <= 8'h00;
         o_RX_Index <= '0;
         remaining  <= '0;
         index      <= '0;
      end else begin
         state      <= state_nxt;
         tmr        <= (state_nxt != state) ? '0 : tmr + TMR_W'(1);
         o_SPI_CS_n <= (state_nxt == IDLE) || (state_nxt == GAP);
         o_Done     <= 1'b0;
         o_RX_DV    <= 1'b0;
         if (state == IDLE && state_nxt == LEAD) begin
            remaining <= i_Count;
            index     <= '0;
            o_Busy    <= 1'b1;
         end
         if (state == GAP && state_nxt == IDLE) begin
            o_Busy <= 1'b0;
            o_Done <= 1'b1;
         end
         if (state == WAIT_RX && i_M_RX_DV) begin
            o_RX_Byte  <= i_M_RX_Byte;
            o_RX_Index <= index;
            o_RX_DV    <= 1'b1;
            index      <= index + CNT_W'(1);
            remaining  <= remaining - CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/spi_byte_sequencer.md
Name: spi_byte_sequencer

Overview:
- Upstream stage feeding SPI_Master's byte interface.
- Buffers TX bytes in a small FIFO and runs multi-byte transactions framed by an active-low chip select with programmable lead, lag and idle times.
- Hands bytes to SPI_Master one at a time through its i_TX_DV/o_TX_Ready handshake and forwards each received byte with its index.
- Lets higher-level controllers issue N-byte SPI transactions without per-byte handshaking.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- CNT_W, 8, width of the transaction byte count.
- CS_LEAD_CLKS, 4, i_clk cycles CS_n is low before the first byte DV.
- CS_LAG_CLKS, 4, i_clk cycles after the last RX byte before CS_n rises.
- CS_IDLE_CLKS, 8, minimum i_clk cycles CS_n stays high between transactions.

Ports:
- i_clk  in  1  system clock; everything is rising-edge.
- i_rst  in  1  synchronous reset, active-high.
- i_TX_Byte  in  8  byte to push into the TX FIFO.
- i_TX_DV  in  1  push strobe; one byte per cycle.
- o_TX_Full  out  1  TX FIFO full; a push while full is dropped.
- o_TX_Empty  out  1  TX FIFO empty.
- i_Start  in  1  start-transaction pulse.
- i_Count  in  CNT_W  bytes in the transaction; sampled when i_Start is accepted.
- o_Busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- o_Done  out  1  one-cycle pulse on the return to IDLE.
- o_RX_Byte  out  8  received byte.
- o_RX_DV  out  1  one-cycle strobe qualifying o_RX_Byte.
- o_RX_Index  out  CNT_W  0-based position of o_RX_Byte within the transaction.
- o_M_TX_Byte  out  8  to SPI_Master i_TX_Byte.
- o_M_TX_DV  out  1  to SPI_Master i_TX_DV.
- i_M_TX_Ready  in  1  from SPI_Master o_TX_Ready.
- i_M_RX_DV  in  1  from SPI_Master o_RX_DV.
- i_M_RX_Byte  in  8  from SPI_Master o_RX_Byte.
- o_SPI_CS_n  out  1  chip select, active-low.

Behaviour:
- Reset values:
  - o_SPI_CS_n=1.
  - o_Busy, o_Done, o_RX_DV, o_M_TX_DV = 0.
  - o_RX_Byte, o_RX_Index, o_M_TX_Byte = 0.
  - FIFO empty: o_TX_Empty=1, o_TX_Full=0.
  - FSM in IDLE.
- Reset mid-transaction: CS_n returns high on the next edge, FIFO contents are discarded, no o_Done pulse.
- FIFO:
  - Registered read/write pointers plus an occupancy counter.
  - Simultaneous push and pop while full: the pop frees the slot, and the push is accepted only if the FIFO is not full at the start of that cycle.
  - Simultaneous push and pop while empty: the push is accepted and no pop occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LEAD, LOAD, WAIT_RX, LAG, GAP.
- IDLE:
  - i_Start with i_Count≠0 latches remaining=i_Count and index=0, then goes to LEAD. CS_n=0 and o_Busy=1 from the next edge.
  - i_Start with i_Count=0 is ignored.
  - i_Start outside IDLE is ignored.
- LEAD: counts CS_LEAD_CLKS cycles, then goes to LOAD.
- LOAD:
  - When !o_TX_Empty && i_M_TX_Ready: drive o_M_TX_Byte = FIFO head, pulse o_M_TX_DV for exactly one cycle, pop the FIFO, go to WAIT_RX.
  - While the FIFO is empty, stall with CS_n held low (underrun is not an error).
- WAIT_RX:
  - On i_M_RX_DV: register o_RX_Byte=i_M_RX_Byte and o_RX_Index=index, and pulse o_RX_DV one cycle later. index++, remaining--.
  - If remaining reaches 0, go to LAG; otherwise go to LOAD.
- LAG: counts CS_LAG_CLKS cycles, then sets CS_n=1 and goes to GAP.
- GAP: counts CS_IDLE_CLKS cycles with CS_n high, then goes to IDLE, pulses o_Done and drops o_Busy on the same edge.
- A count of 0 for any of the CS_*_CLKS timers means the state is left after one cycle.
- o_M_TX_DV never asserts outside LOAD and never on two consecutive cycles.
- i_M_RX_DV outside WAIT_RX is ignored.
- Latency: the first o_M_TX_DV occurs CS_LEAD_CLKS+1 cycles after the start is accepted, provided the FIFO is non-empty and the master is ready.

Test Plan:
- Reset, push 0xC1, Start Count=1, SPI_Master looped MOSI→MISO:
  - CS_n low for the whole transfer.
  - One o_M_TX_DV with 0xC1.
  - o_RX_DV with 0xC1 at index 0.
  - CS_n high CS_LAG_CLKS after RX.
  - o_Done after GAP.
- Push 0xBE, 0xEF, Start Count=2 (loopback):
  - RX 0xBE at index 0, then 0xEF at index 1.
  - CS_n stays low continuously between the bytes.
- Start Count=3 with one byte queued:
  - FSM stalls in LOAD with CS_n low.
  - Push 0x11, 0x22 later: the transfer completes with RX 0x?? in order, o_Done once.
- Push 9 bytes with FIFO_DEPTH=8:
  - o_TX_Full after the 8th push; the 9th byte is dropped.
  - Start Count=8 returns exactly the first 8 bytes.
- Start with Count=0 → no CS activity and no o_Done. Start while o_Busy → ignored; the count does not change.
- Assert i_rst during WAIT_RX of a 4-byte transfer:
  - CS_n=1, o_M_TX_DV=0 and o_TX_Empty=1 on the next edge.
  - No o_Done.
  - A subsequent Start Count=1 works normally.
